// File: rtl/dffram_1r1w_if.sv
// Request/response bundle for dffram_1r1w: independent read and write ports
// plus the sweep-busy and parity-error status.
interface dffram_1r1w_if #(
    parameter int WSIZE = 4,
    parameter int AW    = 7
);
    localparam int DW = 8 * WSIZE;

    logic             BUSY;
    logic             EN_R;
    logic [AW-1:0]    A_R;
    logic [DW-1:0]    Do_R;
    logic             DO_VALID;
    logic [WSIZE-1:0] WE_W;
    logic [AW-1:0]    A_W;
    logic [DW-1:0]    Di_W;
    logic             PERR;

    modport master (
        output EN_R, A_R, WE_W, A_W, Di_W,
        input  BUSY, Do_R, DO_VALID, PERR
    );

    modport slave (
        input  EN_R, A_R, WE_W, A_W, Di_W,
        output BUSY, Do_R, DO_VALID, PERR
    );
endinterface

// File: rtl/dffram_1r1w.sv
// Parametrised 1R1W flop RAM: byte-lane writes, registered read with valid,
// write-first forwarding, optional zero-fill sweep. DFFRAM_PARITY_EN adds per-byte parity.
module dffram_1r1w #(
    parameter int WSIZE         = 4,
    parameter int AW            = 7,
    parameter int INIT_ON_RESET = 1
) (
    input logic          CLK,
    input logic          RESETn,
    dffram_1r1w_if.slave bus
);
    localparam int DW    = 8 * WSIZE;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              r_state;
    logic [AW:0]         r_cnt;
    logic                r_busy;
    logic [DW-1:0]       r_do;
    logic                r_vld;

    logic                w_init;
    logic [AW-1:0]       w_wa;
    logic [WSIZE-1:0]    w_we;
    logic [DW-1:0]       w_wd;
    logic                w_coll;
    logic [WSIZE-1:0][7:0] w_rd;
    logic [WSIZE-1:0]    w_pe;

    // Sweep steals the write port; RESETn gate keeps a held reset from writing.
    assign w_init = (r_state == S_INIT);
    assign w_wa   = w_init ? r_cnt[AW-1:0] : bus.A_W;
    assign w_we   = !RESETn ? '0 : (w_init ? '1 : bus.WE_W);
    assign w_wd   = w_init ? '0 : bus.Di_W;
    assign w_coll = (bus.A_W == bus.A_R);

    genvar gi;
    generate
        for (gi = 0; gi < WSIZE; gi++) begin : g_lane
            logic [7:0] r_byte [DEPTH];
            logic [7:0] w_wbyte;
            logic       w_fwd;

            assign w_wbyte = w_wd[8*gi +: 8];
            assign w_fwd   = bus.WE_W[gi] && w_coll;
            assign w_rd[gi] = w_fwd ? bus.Di_W[8*gi +: 8] : r_byte[bus.A_R];

            always_ff @(posedge CLK) begin
                if (w_we[gi]) r_byte[w_wa] <= w_wbyte;
            end

`ifdef DFFRAM_PARITY_EN
            logic r_par [DEPTH];

            always_ff @(posedge CLK) begin
                if (w_we[gi]) r_par[w_wa] <= ^w_wbyte;
            end

            // Forwarded lanes bypass storage, so they can never flag.
            assign w_pe[gi] = !w_fwd && ((^r_byte[bus.A_R]) != r_par[bus.A_R]);
`else
            assign w_pe[gi] = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
            r_cnt   <= '0;
            r_busy  <= (INIT_ON_RESET != 0);
            r_do    <= '0;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_vld <= 1'b0;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == (AW+1)'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_vld <= bus.EN_R;
                    if (bus.EN_R) r_do <= w_rd;
                end
            endcase
        end
    end

`ifdef DFFRAM_PARITY_EN
    logic r_perr;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)             r_perr <= 1'b0;
        else if (r_state == S_RUN) r_perr <= bus.EN_R && (|w_pe);
        else                     r_perr <= 1'b0;
    end

    assign bus.PERR = r_perr;
`else
    logic w_pe_unused;
    assign w_pe_unused = |w_pe;
    assign bus.PERR    = 1'b0;
`endif

    assign bus.BUSY     = r_busy;
    assign bus.Do_R     = r_do;
    assign bus.DO_VALID = r_vld;
endmodule
